// File: rtl/sb_pkg.sv
// Store buffer shared types.
// Entry layout and default depth.
package sb_pkg;

    localparam int SB_DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_entry_t;

endpackage

// File: rtl/sb_if.sv
// Core/dmem bundle seen by the store buffer.
// slave = buffer side, master = core/memory side.
interface sb_if;

    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Stall;
    logic        Empty;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;

    modport slave (
        input  MemWrite, ALUResult, WriteData, mem_ready, mem_rdata,
        output ReadData, Stall, Empty, mem_we, mem_waddr, mem_wdata,
        output mem_raddr
    );

    modport master (
        output MemWrite, ALUResult, WriteData, mem_ready, mem_rdata,
        input  ReadData, Stall, Empty, mem_we, mem_waddr, mem_wdata,
        input  mem_raddr
    );

endinterface

// File: rtl/sb_fifo.sv
// Circular store FIFO: storage, pointers, occupancy.
// Slots are exported so the owner can scan them for forwarding.
module sb_fifo
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  sb_entry_t     pushEntry,
    input  logic          pop,
    output sb_entry_t     slots [DEPTH],
    output logic [PW-1:0] headPtr,
    output logic [PW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW:0]   cnt;
    logic          doPush;
    logic          doPop;
    sb_entry_t     mem [DEPTH];

    assign full   = (cnt == (PW+1)'(DEPTH));
    assign empty  = (cnt == '0);
    assign doPush = push && !full && !reset;
    assign doPop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (doPush) tail <= tail + 1'b1;
            if (doPop)  head <= head + 1'b1;
            case ({doPush, doPop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Payload needs no reset; validity comes from cnt alone.
    always_ff @(posedge clk) begin
        if (doPush) mem[tail] <= pushEntry;
    end

    assign slots   = mem;
    assign headPtr = head;
    assign count   = cnt;

endmodule

// File: rtl/store_buffer.sv
// Store buffer between core and dmem with load forwarding.
// Youngest matching word wins; otherwise dmem read data passes through.
module store_buffer
    import sb_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic clk,
    input  logic reset,
    sb_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);

    sb_entry_t     slots [DEPTH];
    sb_entry_t     pushEntry;
    sb_entry_t     headEntry;
    logic [PW-1:0] headPtr;
    logic [PW-1:0] idx;
    logic [PW:0]   count;
    logic          full;
    logic          empty;
    logic          fwdHit;
    logic [31:0]   fwdData;

    assign pushEntry = '{addr: bus.ALUResult, data: bus.WriteData};

    sb_fifo #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) uFifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.MemWrite),
        .pushEntry (pushEntry),
        .pop       (bus.mem_ready),
        .slots     (slots),
        .headPtr   (headPtr),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Walk oldest to youngest so the last hit is the youngest store.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = headPtr + PW'(i);
            if ((PW+1)'(i) < count &&
                slots[idx].addr[31:2] == bus.ALUResult[31:2]) begin
                fwdHit  = 1'b1;
                fwdData = slots[idx].data;
            end
        end
    end

    assign headEntry     = slots[headPtr];
    assign bus.ReadData  = fwdHit ? fwdData : bus.mem_rdata;
    assign bus.Stall     = full;
    assign bus.Empty     = empty;
    assign bus.mem_we    = !empty;
    assign bus.mem_waddr = headEntry.addr;
    assign bus.mem_wdata = headEntry.data;
    assign bus.mem_raddr = bus.ALUResult;

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer.
// Vector table plus streaming and reset sequences.
module tb_store_buffer;

    typedef struct {
        logic        mw;
        logic [31:0] addr;
        logic [31:0] data;
        logic        rdy;
        logic [31:0] rdata;
        logic [31:0] expRd;
        logic        expStall;
        logic        expEmpty;
        logic        expWe;
        logic [31:0] expWaddr;
        logic [31:0] expWdata;
    } vec_t;

    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] RD2 = 32'h12345678;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs [$];

    sb_if bus ();

    store_buffer #(.DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic mw, input logic [31:0] addr, input logic [31:0] data,
        input logic rdy, input logic [31:0] rdata, input logic [31:0] rd,
        input logic st, input logic em, input logic we,
        input logic [31:0] wa, input logic [31:0] wd);
        vec_t v;
        v.mw = mw; v.addr = addr; v.data = data; v.rdy = rdy;
        v.rdata = rdata; v.expRd = rd; v.expStall = st;
        v.expEmpty = em; v.expWe = we; v.expWaddr = wa; v.expWdata = wd;
        return v;
    endfunction

    task automatic drive(input logic mw, input logic [31:0] addr,
                         input logic [31:0] data, input logic rdy,
                         input logic [31:0] rdata);
        bus.MemWrite  = mw;
        bus.ALUResult = addr;
        bus.WriteData = data;
        bus.mem_ready = rdy;
        bus.mem_rdata = rdata;
    endtask

    task automatic doReset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, DB);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, DB);
        // idle / single store
        vecs.push_back(mk(0, 32'h100, 0, 0, DB, DB, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'h10, 32'h11111111, 0, DB, DB, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 32'h10, 0, 0, DB, 32'h11111111, 0, 0, 1, 32'h10, 32'h11111111));
        vecs.push_back(mk(0, 32'h10, 0, 1, DB, 32'h11111111, 0, 0, 1, 32'h10, 32'h11111111));
        vecs.push_back(mk(0, 32'h10, 0, 0, DB, DB, 0, 1, 0, 0, 0));
        // fill to full, held fifth store, drain in order
        vecs.push_back(mk(1, 32'h0, 32'hA0, 0, DB, DB, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'h4, 32'hA4, 0, DB, DB, 0, 0, 1, 32'h0, 32'hA0));
        vecs.push_back(mk(1, 32'h8, 32'hA8, 0, DB, DB, 0, 0, 1, 32'h0, 32'hA0));
        vecs.push_back(mk(1, 32'hC, 32'hAC, 0, DB, DB, 0, 0, 1, 32'h0, 32'hA0));
        vecs.push_back(mk(1, 32'h30, 32'hF5, 0, DB, DB, 1, 0, 1, 32'h0, 32'hA0));
        vecs.push_back(mk(1, 32'h30, 32'hF5, 1, DB, DB, 1, 0, 1, 32'h0, 32'hA0));
        vecs.push_back(mk(1, 32'h30, 32'hF5, 1, DB, DB, 0, 0, 1, 32'h4, 32'hA4));
        vecs.push_back(mk(0, 32'h30, 0, 1, DB, 32'hF5, 0, 0, 1, 32'h8, 32'hA8));
        vecs.push_back(mk(0, 32'hC, 0, 1, DB, 32'hAC, 0, 0, 1, 32'hC, 32'hAC));
        vecs.push_back(mk(0, 32'h0, 0, 1, DB, DB, 0, 0, 1, 32'h30, 32'hF5));
        vecs.push_back(mk(0, 32'h0, 0, 0, DB, DB, 0, 1, 0, 0, 0));
        // duplicate address, youngest forwards, byte offset ignored
        vecs.push_back(mk(1, 32'h20, 32'hA, 0, DB, DB, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'h20, 32'hB, 0, DB, 32'hA, 0, 0, 1, 32'h20, 32'hA));
        vecs.push_back(mk(0, 32'h20, 0, 0, DB, 32'hB, 0, 0, 1, 32'h20, 32'hA));
        vecs.push_back(mk(0, 32'h22, 0, 1, DB, 32'hB, 0, 0, 1, 32'h20, 32'hA));
        vecs.push_back(mk(0, 32'h22, 0, 1, DB, 32'hB, 0, 0, 1, 32'h20, 32'hB));
        vecs.push_back(mk(0, 32'h20, 0, 0, RD2, RD2, 0, 1, 0, 0, 0));
        vecs.push_back(mk(1, 32'h23, 32'hC, 0, RD2, RD2, 0, 1, 0, 0, 0));
        vecs.push_back(mk(0, 32'h20, 0, 0, RD2, 32'hC, 0, 0, 1, 32'h23, 32'hC));
        vecs.push_back(mk(0, 32'h20, 0, 1, RD2, 32'hC, 0, 0, 1, 32'h23, 32'hC));
        vecs.push_back(mk(0, 32'h20, 0, 0, RD2, RD2, 0, 1, 0, 0, 0));

        @(posedge clk); #1;
        doReset();

        foreach (vecs[i]) begin
            drive(vecs[i].mw, vecs[i].addr, vecs[i].data,
                  vecs[i].rdy, vecs[i].rdata);
            @(negedge clk);
            chk($sformatf("v%0d ReadData", i), bus.ReadData, vecs[i].expRd);
            chk($sformatf("v%0d Stall", i), 32'(bus.Stall), 32'(vecs[i].expStall));
            chk($sformatf("v%0d Empty", i), 32'(bus.Empty), 32'(vecs[i].expEmpty));
            chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(vecs[i].expWe));
            chk($sformatf("v%0d mem_raddr", i), bus.mem_raddr, vecs[i].addr);
            if (vecs[i].expWe) begin
                chk($sformatf("v%0d mem_waddr", i), bus.mem_waddr, vecs[i].expWaddr);
                chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, vecs[i].expWdata);
            end
            @(posedge clk); #1;
        end

        // streaming store every cycle with dmem always ready
        doReset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 32'h40 + 32'(4 * i), 32'h100 + 32'(i), 1'b1, DB);
            @(negedge clk);
            chk($sformatf("s%0d Stall", i), 32'(bus.Stall), 32'd0);
            chk($sformatf("s%0d Empty", i), 32'(bus.Empty), (i == 0) ? 32'd1 : 32'd0);
            if (i > 0) begin
                chk($sformatf("s%0d mem_waddr", i), bus.mem_waddr,
                    32'h40 + 32'(4 * (i - 1)));
                chk($sformatf("s%0d mem_wdata", i), bus.mem_wdata,
                    32'h100 + 32'(i - 1));
            end
            @(posedge clk); #1;
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, DB);
        @(negedge clk);
        chk("s_last mem_waddr", bus.mem_waddr, 32'h6C);
        chk("s_last mem_wdata", bus.mem_wdata, 32'h10B);
        @(posedge clk); #1;
        @(negedge clk);
        chk("s_end Empty", 32'(bus.Empty), 32'd1);
        @(posedge clk); #1;

        // reset while three stores pend; store during reset is dropped
        doReset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h50 + 32'(4 * i), 32'h200 + 32'(i), 1'b0, DB);
            @(posedge clk); #1;
        end
        reset = 1'b1;
        drive(1'b1, 32'h60, 32'h77, 1'b0, DB);
        @(negedge clk);
        chk("r_pre mem_we", 32'(bus.mem_we), 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 32'h60, 32'h0, 1'b1, DB);
        @(negedge clk);
        chk("r Empty", 32'(bus.Empty), 32'd1);
        chk("r Stall", 32'(bus.Stall), 32'd0);
        chk("r ReadData", bus.ReadData, DB);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(1'b0, 32'h50, 32'h0, 1'b1, RD2);
            @(negedge clk);
            chk($sformatf("r%0d mem_we", i), 32'(bus.mem_we), 32'd0);
            chk($sformatf("r%0d ReadData", i), bus.ReadData, RD2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The module SHALL have parameter DEPTH, default 4, meaning the number of buffered stores (power of two, 2..16).
REQ-002 The module SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, reset, synchronous and active-high.
REQ-004 The module SHALL have port MemWrite, input, 1, core store request.
REQ-005 The module SHALL have port ALUResult, input, 32, core byte address for both store and load.
REQ-006 The module SHALL have port WriteData, input, 32, core store data (full word).
REQ-007 The module SHALL have port ReadData, output, 32, load data returned to the core.
REQ-008 The module SHALL have port Stall, output, 1, buffer full; core must hold its store.
REQ-009 The module SHALL have port Empty, output, 1, no pending stores.
REQ-010 The module SHALL have port mem_we, output, 1, write strobe to dmem.
REQ-011 The module SHALL have port mem_waddr, output, 32, dmem write address.
REQ-012 The module SHALL have port mem_wdata, output, 32, dmem write data.
REQ-013 The module SHALL have port mem_ready, input, 1, dmem accepts the write this cycle.
REQ-014 The module SHALL have port mem_raddr, output, 32, dmem read address (equals ALUResult, combinational).
REQ-015 The module SHALL have port mem_rdata, input, 32, dmem read data (combinational).

Function
REQ-016 Circular FIFO of DEPTH {addr, data} entries; head/tail pointers wrap modulo DEPTH; occupancy count 0..DEPTH.
REQ-017 Enqueue SHALL occur at the edge where MemWrite=1 and count<DEPTH; a new entry becomes visible (forwarding, drain) the next cycle.
REQ-018 Stall SHALL equal (count==DEPTH), decoded from registered state only; while full, MemWrite is not accepted even if a drain occurs in the same cycle.
REQ-019 mem_we SHALL equal (count!=0); mem_waddr/mem_wdata SHALL present the head entry.
REQ-020 The head entry SHALL retire at the edge where mem_we=1 and mem_ready=1; exactly one retire per cycle maximum.
REQ-021 Simultaneous enqueue and retire SHALL leave count unchanged and advance both pointers.
REQ-022 Forwarding: ReadData SHALL be the data of the youngest valid entry whose addr[31:2] equals ALUResult[31:2]; with no match ReadData = mem_rdata.
REQ-023 A store accepted in the current cycle SHALL NOT forward to a load issued in the same cycle.
REQ-024 Stores are word-only; addr[1:0] SHALL be stored but ignored in comparison.
REQ-025 Empty SHALL equal (count==0).
REQ-026 Duplicate addresses in the buffer SHALL be drained in program order (no coalescing).

Reset
REQ-027 While reset=1 at a clock edge: count, head, tail SHALL become 0; all pending entries SHALL be discarded, including mid-drain.
REQ-028 After reset: mem_we=0, Stall=0, Empty=1, ReadData=mem_rdata; entry storage need not be cleared.
REQ-029 MemWrite asserted in the same cycle as reset SHALL NOT be enqueued.

Structure
REQ-030 Package sb_pkg SHALL hold the default DEPTH constant and the sb_entry_t struct {addr[31:0], data[31:0]}.
REQ-031 One sub-module, sb_fifo (storage, pointers, count, full/empty), SHALL be instantiated; the forwarding comparators and port muxing SHALL live in store_buffer.

Verification
REQ-032 Reset, then idle: Empty=1, Stall=0, mem_we=0, ReadData tracks mem_rdata=32'hDEADBEEF.
REQ-033 Store 0x10<-0x11111111 with mem_ready=0, then load 0x10 -> ReadData=0x11111111; next cycle mem_ready=1 -> mem_we=1, mem_waddr=0x10, mem_wdata=0x11111111, Empty=1 one cycle later.
REQ-034 With mem_ready=0, four stores to 0x0,0x4,0x8,0xC -> Stall=1 after the fourth; fifth store held; mem_ready=1 -> drain order 0x0,0x4,0x8,0xC; the held fifth store is accepted the cycle after Stall drops.
REQ-035 Stores 0x20<-0xA then 0x20<-0xB (mem_ready=0) -> load 0x20 returns 0xB; load 0x22 also returns 0xB; drain writes 0xA then 0xB.
REQ-036 Continuous store every cycle with mem_ready=1 -> count stays 1, pointers wrap past DEPTH-1 cleanly across at least 10 stores, no Stall.
REQ-037 Three stores pending, reset asserted one cycle -> Empty=1 and mem_we=0 after the edge; no further dmem writes occur.
